conv3x3_stream: RTL



---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_line_buffer.sv | 37 +++
 rtl/conv3x3_stream.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and window/weight array types for the 3x3 convolution stage.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int W_W    = 8;
    localparam int OUT_W  = 22;
    localparam int PROD_W = PIX_W + W_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // Indexed [row][col]; row 0 is the oldest (top) image row of the window.
    typedef logic signed [W_W-1:0]   weight_arr_t [3][3];
    typedef logic signed [PIX_W-1:0] pix_win_t    [3][3];
endpackage

// File: rtl/conv_line_buffer.sv
// Two IMG_WIDTH-deep row stores returning the vertical 3-pixel column at x; write is one cycle.
// No backpressure: a column is read and the rows are rotated on every write-enable.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = 32,
    parameter int XW        = $clog2(IMG_WIDTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [XW-1:0]           x_addr,
    input  logic signed [PIX_W-1:0] pix_in,
    output logic signed [PIX_W-1:0] col_top,
    output logic signed [PIX_W-1:0] col_mid,
    output logic signed [PIX_W-1:0] col_bot
);
    logic signed [PIX_W-1:0] row1_q [IMG_WIDTH];   // row y-2
    logic signed [PIX_W-1:0] row0_q [IMG_WIDTH];   // row y-1
    logic signed [PIX_W-1:0] row1_d;
    logic signed [PIX_W-1:0] row0_d;

    always_comb begin
        row1_d = row0_q[x_addr];
        row0_d = pix_in;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            row1_q[x_addr] <= row1_d;
            row0_q[x_addr] <= row0_d;
        end
    end

    assign col_top = row1_q[x_addr];
    assign col_mid = row0_q[x_addr];
    assign col_bot = pix_in;
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution; result 2 cycles after the window-completing pixel, no backpressure.
// Optional macro CONV_RELU_EN clamps negative sums to zero in the output stage.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_signal,
    input  logic [9*W_W-1:0]        weight_in,
    input  logic                    pixel_valid,
    input  logic signed [PIX_W-1:0] pixel_in,
    output logic signed [OUT_W-1:0] result_out,
    output logic                    result_valid,
    output logic                    done_signal
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    conv_state_e state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    weight_arr_t   w_q, w_d;
    pix_win_t      win_q, win_d;
    logic          win_vld_q, win_vld_d;
    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic          prod_vld_q, prod_vld_d;
    logic signed [OUT_W-1:0] res_q, res_d;
    logic          res_vld_q, res_vld_d;
    logic signed [OUT_W-1:0] sum;
    logic          accept;
    logic signed [PIX_W-1:0] col_top, col_mid, col_bot;

    assign accept = (state_q == RUN) && pixel_valid;

    conv_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .XW(XW)) u_line_buffer (
        .clk     (clk),
        .we      (accept),
        .x_addr  (x_q),
        .pix_in  (pixel_in),
        .col_top (col_top),
        .col_mid (col_mid),
        .col_bot (col_bot)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        win_d     = win_q;
        win_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_signal) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            w_d[r][c]   = weight_in[W_W*(3*r+c) +: W_W];
                            win_d[r][c] = '0;
                        end
                    end
                end
            end
            RUN: begin
                if (pixel_valid) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r][0] = win_q[r][1];
                        win_d[r][1] = win_q[r][2];
                    end
                    win_d[0][2] = col_top;
                    win_d[1][2] = col_mid;
                    win_d[2][2] = col_bot;
                    // Columns x-2..x are all from the current row only once x >= 2.
                    win_vld_d = (x_q >= X_TWO) && (y_q >= Y_TWO);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) state_d = FLUSH;
                        else               y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Last result is in the output register this cycle; done follows it.
                if (!win_vld_q && !prod_vld_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[3*r+c] = win_q[r][c] * w_q[r][c];
            end
        end
        prod_vld_d = win_vld_q;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + {{(OUT_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
        res_d     = res_q;
        res_vld_d = prod_vld_q;
        if (prod_vld_q) begin
`ifdef CONV_RELU_EN
            res_d = sum[OUT_W-1] ? '0 : sum;
`else
            res_d = sum;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            win_vld_q  <= 1'b0;
            prod_vld_q <= 1'b0;
            res_vld_q  <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            win_vld_q  <= win_vld_d;
            prod_vld_q <= prod_vld_d;
            res_vld_q  <= res_vld_d;
            res_q      <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q    <= w_d;
        win_q  <= win_d;
        prod_q <= prod_d;
    end

    assign result_out   = res_q;
    assign result_valid = res_vld_q;
    assign done_signal  = (state_q == DONE);
endmodule
